// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the MIPS datapath.
//
// Purpose
//   Holds DEPTH registers of DATA_W bits with one synchronous write port and
//   NUM_READ registered read ports (1-cycle latency). A read that hits the
//   address being written in the same cycle is forwarded from wr_data.
//   Register 0 can be hardwired to zero. A per-register pending-write
//   scoreboard lets decode stall on outstanding multi-cycle producers.
//   Two fixed taps expose the registers the syscall unit needs.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   rd_en      in   [NUM_READ]          per-port read enable
//   rd_addr    in   [NUM_READ*AW]       port i at [i*AW +: AW]
//   rd_data    out  [NUM_READ*DATA_W]   registered, port i at [i*DATA_W +: DATA_W]
//   rd_busy    out  [NUM_READ]          combinational hazard flag per port
//   wr_en      in   write enable
//   wr_addr    in   [AW] write address
//   wr_data    in   [DATA_W] write data
//   resv_en    in   mark a register as pending
//   resv_addr  in   [AW] register to mark
//   pending    out  [DEPTH] scoreboard vector
//   tap_a      out  [DATA_W] reg[TAP_A_IDX]
//   tap_b      out  [DATA_W] reg[TAP_B_IDX]
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG  = 1,
    parameter int TAP_A_IDX = 2,
    parameter int TAP_B_IDX = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_READ-1:0]          rd_en,
    input  logic [NUM_READ*AW-1:0]       rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         resv_en,
    input  logic [AW-1:0]                resv_addr,
    output logic [DEPTH-1:0]             pending,
    output logic [DATA_W-1:0]            tap_a,
    output logic [DATA_W-1:0]            tap_b
);

    localparam bit            ZERO_EN    = (ZERO_REG != 0);
    localparam logic [AW-1:0] TAP_A_ADDR = AW'(TAP_A_IDX);
    localparam logic [AW-1:0] TAP_B_ADDR = AW'(TAP_B_IDX);

    logic [DATA_W-1:0]          regs_q [DEPTH];
    logic [DATA_W-1:0]          regs_d [DEPTH];
    logic [NUM_READ*DATA_W-1:0] rd_data_q;
    logic [NUM_READ*DATA_W-1:0] rd_data_d;
    logic [DEPTH-1:0]           pending_q;
    logic [DEPTH-1:0]           pending_d;
    logic [NUM_READ-1:0]        rd_busy_s;
    logic                       wr_ok_s;

    // A write to register 0 is dropped when it is hardwired to zero; such a
    // write must neither update storage nor be forwarded.
    assign wr_ok_s = wr_en & ~(ZERO_EN & (wr_addr == {AW{1'b0}}));

    // Next register contents: only the written entry changes.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            regs_d[j] = (wr_ok_s && (wr_addr == AW'(j))) ? wr_data : regs_q[j];
        end
    end

    // Next read data per port: zero register, then forwarding, then storage.
    always_comb begin
        logic [AW-1:0] ra;
        rd_data_d = rd_data_q;
        ra        = {AW{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (rd_en[i]) begin
                if (ZERO_EN && (ra == {AW{1'b0}})) begin
                    rd_data_d[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                end else if (wr_ok_s && (wr_addr == ra)) begin
                    rd_data_d[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data_d[i*DATA_W +: DATA_W] = regs_q[ra];
                end
            end else begin
                rd_data_d[i*DATA_W +: DATA_W] = rd_data_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next scoreboard: a new reservation beats a completing write, because
    // the new producer supersedes the old one.
    always_comb begin
        pending_d = pending_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (ZERO_EN && (j == 0)) begin
                pending_d[j] = 1'b0;
            end else if (resv_en && (resv_addr == AW'(j))) begin
                pending_d[j] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(j))) begin
                pending_d[j] = 1'b0;
            end else begin
                pending_d[j] = pending_q[j];
            end
        end
    end

    // Per-port hazard: pending unless this cycle's write resolves it by forwarding.
    always_comb begin
        logic [AW-1:0] ra;
        rd_busy_s = {NUM_READ{1'b0}};
        ra        = {AW{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            ra           = rd_addr[i*AW +: AW];
            rd_busy_s[i] = pending_q[ra] & ~(wr_en & (wr_addr == ra));
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs_q[j] <= {DATA_W{1'b0}};
            end
            rd_data_q <= {(NUM_READ*DATA_W){1'b0}};
            pending_q <= {DEPTH{1'b0}};
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                regs_q[j] <= regs_d[j];
            end
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_s;
    assign pending = pending_q;
    // Taps show committed contents only; they are deliberately not forwarded.
    assign tap_a   = regs_q[TAP_A_ADDR];
    assign tap_b   = regs_q[TAP_B_ADDR];

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model, and a second instance
// with a 64-bit, 16-entry, 4-port, no-zero-register configuration.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;

    // Default configuration instance
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        resv_en;
    logic [4:0]  resv_addr;
    logic [31:0] pending;
    logic [31:0] tap_a;
    logic [31:0] tap_b;

    // Wide configuration instance
    logic [3:0]   p_rd_en;
    logic [15:0]  p_rd_addr;
    logic [255:0] p_rd_data;
    logic [3:0]   p_rd_busy;
    logic         p_wr_en;
    logic [3:0]   p_wr_addr;
    logic [63:0]  p_wr_data;
    logic         p_resv_en;
    logic [3:0]   p_resv_addr;
    logic [15:0]  p_pending;
    logic [63:0]  p_tap_a;
    logic [63:0]  p_tap_b;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_rd   [2];

    regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .pending   (pending),
        .tap_a     (tap_a),
        .tap_b     (tap_b)
    );

    regfile_mp #(
        .DATA_W   (64),
        .DEPTH    (16),
        .NUM_READ (4),
        .ZERO_REG (0)
    ) dut_p (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (p_rd_en),
        .rd_addr   (p_rd_addr),
        .rd_data   (p_rd_data),
        .rd_busy   (p_rd_busy),
        .wr_en     (p_wr_en),
        .wr_addr   (p_wr_addr),
        .wr_data   (p_wr_data),
        .resv_en   (p_resv_en),
        .resv_addr (p_resv_addr),
        .pending   (p_pending),
        .tap_a     (p_tap_a),
        .tap_b     (p_tap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int j = 0; j < 32; j++) m_regs[j] = 32'h0;
        m_pend  = 32'h0;
        m_rd[0] = 32'h0;
        m_rd[1] = 32'h0;
    endtask

    // Behaviour of one clock edge, from the register-file rules.
    task automatic model_edge();
        int a;
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) begin
                a = int'(rd_addr[i*5 +: 5]);
                if (a == 0)                              m_rd[i] = 32'h0;
                else if (wr_en && int'(wr_addr) == a)    m_rd[i] = wr_data;
                else                                     m_rd[i] = m_regs[a];
            end
        end
        if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        if (wr_en)                    m_pend[wr_addr] = 1'b0;
        if (resv_en && resv_addr != 5'd0) m_pend[resv_addr] = 1'b1;
    endtask

    function automatic logic [1:0] model_busy();
        logic [1:0] b;
        for (int i = 0; i < 2; i++) begin
            b[i] = m_pend[rd_addr[i*5 +: 5]] && !(wr_en && wr_addr == rd_addr[i*5 +: 5]);
        end
        return b;
    endfunction

    task automatic idle();
        rd_en = 2'b00; wr_en = 1'b0; resv_en = 1'b0;
        p_rd_en = 4'h0; p_wr_en = 1'b0; p_resv_en = 1'b0;
    endtask

    // Advance one clock, keep the model in step, then settle.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_addr = 5'd2; wr_data = 32'h0000_0011;
        resv_en = 1'b1; resv_addr = 5'd5;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        step();
        idle();
        rd_addr = {5'd5, 5'd5};
        tests_run++;
        if (rd_data !== 64'hDEADBEEF_DEADBEEF || tap_a !== 32'h11 || pending[5] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_preload: rd_data=%h tap_a=%h pending=%h", rd_data, tap_a, pending);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (rd_data !== 64'h0 || pending !== 32'h0 || tap_a !== 32'h0 || tap_b !== 32'h0 || rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_async: rd_data=%h pending=%h tap_a=%h tap_b=%h busy=%b want all 0",
                     rd_data, pending, tap_a, tap_b, rd_busy);
        end
        #1;
        rst_n = 1'b1;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        step();
        idle();
        tests_run++;
        if (rd_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_read_r5: got %h want 0", rd_data[31:0]);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
        step();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        tests_run++;
        if (rd_data[31:0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL write_read: got %h want 12345678", rd_data[31:0]);
        end
        idle();
        rd_addr = {5'd6, 5'd6};
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BADF00D;
        step();
        idle();
        tests_run++;
        if (rd_data[31:0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL read_hold: got %h want 12345678", rd_data[31:0]);
        end
    endtask

    task automatic test_forwarding();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
        step();
        tests_run++;
        if (rd_data !== 64'hA5A5A5A5_A5A5A5A5) begin
            tests_failed++;
            $display("FAIL forward_r7: got %h want A5A5A5A5A5A5A5A5", rd_data);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        idle();
        tests_run++;
        if (rd_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL forward_r0: got %h want 0", rd_data);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        resv_en = 1'b1; resv_addr = 5'd9;
        step();
        idle();
        rd_addr = {5'd9, 5'd9};
        #1;
        tests_run++;
        if (pending[9] !== 1'b1 || rd_busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL sb_reserve: pending9=%b busy=%b want 1/11", pending[9], rd_busy);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        tests_run++;
        if (rd_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL sb_fwd_clear: busy=%b want 00", rd_busy);
        end
        step();
        idle();
        tests_run++;
        if (pending[9] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_write_clear: pending9=%b want 0", pending[9]);
        end
        resv_en = 1'b1; resv_addr = 5'd9;
        step();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h123;
        resv_en = 1'b1; resv_addr = 5'd9;
        step();
        resv_en = 1'b1; resv_addr = 5'd0;
        wr_en = 1'b0;
        step();
        idle();
        tests_run++;
        if (pending[9] !== 1'b1 || pending[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_set_wins: pending9=%b pending0=%b want 1/0", pending[9], pending[0]);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0;
        step();
        idle();
    endtask

    task automatic test_taps();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd10;
        step();
        wr_addr = 5'd4; wr_data = 32'h1000;
        step();
        idle();
        tests_run++;
        if (tap_a !== 32'd10 || tap_b !== 32'h1000) begin
            tests_failed++;
            $display("FAIL taps: tap_a=%h tap_b=%h want a/1000", tap_a, tap_b);
        end
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
        #1;
        tests_run++;
        if (tap_a !== 32'd10) begin
            tests_failed++;
            $display("FAIL tap_not_fwd: tap_a=%h want a", tap_a);
        end
        step();
        idle();
        tests_run++;
        if (tap_a !== 32'h77) begin
            tests_failed++;
            $display("FAIL tap_update: tap_a=%h want 77", tap_a);
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_busy;
        for (int n = 0; n < 300; n++) begin
            rd_en     = 2'($urandom_range(0, 3));
            rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            resv_en   = ($urandom_range(0, 3) == 0);
            resv_addr = 5'($urandom_range(0, 7));
            #1;
            exp_busy = model_busy();
            tests_run++;
            if (rd_busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL rand_busy[%0d]: got %b want %b", n, rd_busy, exp_busy);
            end
            step();
            tests_run++;
            if (rd_data !== {m_rd[1], m_rd[0]} || pending !== m_pend ||
                tap_a !== m_regs[2] || tap_b !== m_regs[4]) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: rd=%h/%h pend=%h/%h ta=%h/%h tb=%h/%h (got/want)",
                         n, rd_data, {m_rd[1], m_rd[0]}, pending, m_pend,
                         tap_a, m_regs[2], tap_b, m_regs[4]);
            end
        end
        idle();
    endtask

    task automatic test_param();
        idle();
        p_wr_en = 1'b1; p_wr_addr = 4'd0; p_wr_data = 64'h1;
        p_rd_en = 4'hF; p_rd_addr = 16'h0000;
        step();
        p_wr_en = 1'b0;
        tests_run++;
        if (p_rd_data !== {64'h1, 64'h1, 64'h1, 64'h1}) begin
            tests_failed++;
            $display("FAIL param_fwd_r0: got %h", p_rd_data);
        end
        p_rd_data_clear();
        p_rd_en = 4'hF; p_rd_addr = 16'h0000;
        step();
        tests_run++;
        if (p_rd_data !== {64'h1, 64'h1, 64'h1, 64'h1}) begin
            tests_failed++;
            $display("FAIL param_read_r0: got %h", p_rd_data);
        end
        p_rd_en = 4'h0;
        p_resv_en = 1'b1; p_resv_addr = 4'd0;
        p_wr_en = 1'b1; p_wr_addr = 4'd2; p_wr_data = 64'hFEDC_BA98_7654_3210;
        step();
        idle();
        p_rd_addr = 16'h0000;
        #1;
        tests_run++;
        if (p_pending !== 16'h0001 || p_rd_busy !== 4'hF || p_tap_a !== 64'hFEDC_BA98_7654_3210) begin
            tests_failed++;
            $display("FAIL param_sb_tap: pending=%h busy=%h tap_a=%h", p_pending, p_rd_busy, p_tap_a);
        end
    endtask

    // Load other values into every wide port so the next read of reg0 is a real update.
    task automatic p_rd_data_clear();
        p_wr_en = 1'b1; p_wr_addr = 4'd5; p_wr_data = 64'h5555;
        p_rd_en = 4'hF; p_rd_addr = 16'h5555;
        step();
        p_wr_en = 1'b0;
        tests_run++;
        if (p_rd_data !== {64'h5555, 64'h5555, 64'h5555, 64'h5555}) begin
            tests_failed++;
            $display("FAIL param_r5: got %h", p_rd_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = 10'h0; wr_addr = 5'h0; wr_data = 32'h0; resv_addr = 5'h0;
        p_rd_addr = 16'h0; p_wr_addr = 4'h0; p_wr_data = 64'h0; p_resv_addr = 4'h0;
        idle();
        model_reset();
        #2;
        tests_run++;
        if (rd_data !== 64'h0 || pending !== 32'h0 || tap_a !== 32'h0 || p_rd_data !== 256'h0) begin
            tests_failed++;
            $display("FAIL initial_reset: rd_data=%h pending=%h tap_a=%h", rd_data, pending, tap_a);
        end
        #1;
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_forwarding();
        test_scoreboard();
        test_taps();
        test_random();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
